// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction-memory geometry and the loader state encoding.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0040_0000;
  localparam int unsigned IMEM_DEPTH     = 257;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts bytes in MSB-first and flags the byte that completes a 32-bit word.
module byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);

  logic [31:0] word;
  logic [1:0]  count;

  // word_next is the word as it will look after this byte, so the top can capture
  // it on the same edge that completes it
  assign word_next  = {word[23:0], byte_in};
  assign word_ready = shift_en && (count == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (shift_en) begin
      word  <= word_next;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed byte stream and writes it as big-endian words into
// instruction memory, stalling the CPU while the program is loaded.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
  parameter int unsigned DEPTH     = IMEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_stall,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  loader_state_t state, state_next;
  logic [15:0]   len;
  logic [15:0]   len_full;
  logic          load_start;
  logic          shift_en;
  logic [31:0]   word_next;
  logic          word_ready;

  // The low length byte is decided on as it arrives, so combine it with the stored high byte
  assign len_full   = {len[15:8], in_data};
  assign load_start = ((state == IDLE) || (state == DONE) || (state == ERROR)) && start;
  assign shift_en   = (state == DATA) && in_valid;

  byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (load_start),
    .shift_en   (shift_en),
    .byte_in    (in_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cpu_stall  = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_next = LEN_HI;
      end
      LEN_HI: begin
        in_ready  = 1'b1;
        cpu_stall = 1'b1;
        if (in_valid) state_next = LEN_LO;
      end
      LEN_LO: begin
        in_ready  = 1'b1;
        cpu_stall = 1'b1;
        if (in_valid) begin
          if (len_full == 16'd0)          state_next = DONE;
          else if (len_full > DEPTH16)    state_next = ERROR;
          else                            state_next = DATA;
        end
      end
      DATA: begin
        in_ready  = 1'b1;
        cpu_stall = 1'b1;
        if (word_ready) state_next = WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        cpu_stall = 1'b1;
        if ((words_written + 16'd1) == len) state_next = DONE;
        else                                state_next = DATA;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address and data are latched with the completing byte so they are stable for the
  // whole WRITE cycle and hold afterwards
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      len           <= '0;
      words_written <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      state <= state_next;
      if (load_start) begin
        done          <= 1'b0;
        error         <= 1'b0;
        words_written <= '0;
      end
      if ((state == LEN_HI) && in_valid) len[15:8] <= in_data;
      if ((state == LEN_LO) && in_valid) len[7:0]  <= in_data;
      if (word_ready) begin
        wr_data <= word_next;
        wr_addr <= BASE_ADDR + {14'd0, words_written, 2'b00};
      end
      if (state == WRITE) words_written <= words_written + 16'd1;
      if ((state != DONE)  && (state_next == DONE))  done  <= 1'b1;
      if ((state != ERROR) && (state_next == ERROR)) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads plus random loads against a
// stream-level model of the expected memory writes, and hand-written reset/busy cases.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 257;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_stall;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  typedef struct {
    int len;
    int gap;
    bit fixed;
    bit hold_start;
    bit exp_done;
    bit exp_error;
    int exp_words;
  } vec_t;

  vec_t vecs[$];

  imem_loader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cpu_stall     (cpu_stall),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Record every memory write; a write cycle must never also accept a byte
  always @(negedge clk) begin
    if (reset_n && wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      check("in_ready_during_write", {31'd0, in_ready}, 32'd0);
      check("stall_during_write", {31'd0, cpu_stall}, 32'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) check("byte_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expected writes: word i goes to BASE+4i, built from data bytes 4i..4i+3 MSB first
  task automatic build_expected(input int len, input logic [7:0] bytes[$]);
    exp_addr.delete();
    exp_data.delete();
    if (len <= DEPTH) begin
      for (int i = 0; i < len; i++) begin
        exp_addr.push_back(BASE + 32'(4 * i));
        exp_data.push_back({bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]});
      end
    end
  endtask

  task automatic apply_stimulus(input int len, input int gap, input bit fixed, input bit hold_start);
    logic [7:0]  bytes[$];
    logic [7:0]  fixed_bytes[8];
    logic [15:0] l16;
    int          n_data;
    int          t;
    fixed_bytes = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    l16    = 16'(len);
    n_data = (len <= DEPTH) ? 4 * len : 0;
    for (int i = 0; i < n_data; i++)
      bytes.push_back(fixed ? fixed_bytes[i % 8] : 8'($urandom));
    build_expected(len, bytes);
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_byte(l16[15:8], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    send_byte(l16[7:0],  (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    if (len > 0 && len <= DEPTH) check("stall_while_loading", {31'd0, cpu_stall}, 32'd1);
    for (int i = 0; i < n_data; i++) begin
      if (hold_start && i == 4)          start = 1'b1;
      if (hold_start && i == n_data - 4) start = 1'b0;
      send_byte(bytes[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    end
    t = 0;
    while (!(done || error) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("load_completes", {31'd0, done | error}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input bit e_done, input bit e_err, input int e_words);
    check({tag, "_done"},  {31'd0, done},  {31'd0, e_done});
    check({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
    check({tag, "_words_written"}, {16'd0, words_written}, 32'(e_words));
    check({tag, "_stall_released"}, {31'd0, cpu_stall}, 32'd0);
    check({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_write_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check({tag, "_wr_addr"}, got_addr[i], exp_addr[i]);
      check({tag, "_wr_data"}, got_data[i], exp_data[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check({tag, "_wr_en"},     {31'd0, wr_en},     32'd0);
    check({tag, "_cpu_stall"}, {31'd0, cpu_stall}, 32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_error"},     {31'd0, error},     32'd0);
    check({tag, "_words"},     {16'd0, words_written}, 32'd0);
    check({tag, "_wr_addr"},   wr_addr, 32'd0);
    check({tag, "_wr_data"},   wr_data, 32'd0);
  endtask

  initial begin
    int rl;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    vecs.push_back('{len: 2,     gap: 0,  fixed: 1, hold_start: 0, exp_done: 1, exp_error: 0, exp_words: 2});
    vecs.push_back('{len: 2,     gap: 1,  fixed: 1, hold_start: 0, exp_done: 1, exp_error: 0, exp_words: 2});
    vecs.push_back('{len: 258,   gap: 0,  fixed: 0, hold_start: 0, exp_done: 0, exp_error: 1, exp_words: 0});
    vecs.push_back('{len: 1,     gap: 0,  fixed: 0, hold_start: 0, exp_done: 1, exp_error: 0, exp_words: 1});
    vecs.push_back('{len: 257,   gap: 0,  fixed: 0, hold_start: 0, exp_done: 1, exp_error: 0, exp_words: 257});
    vecs.push_back('{len: 0,     gap: 0,  fixed: 0, hold_start: 0, exp_done: 1, exp_error: 0, exp_words: 0});
    vecs.push_back('{len: 3,     gap: -1, fixed: 0, hold_start: 1, exp_done: 1, exp_error: 0, exp_words: 3});
    vecs.push_back('{len: 5,     gap: -1, fixed: 0, hold_start: 0, exp_done: 1, exp_error: 0, exp_words: 5});
    vecs.push_back('{len: 65535, gap: 0,  fixed: 0, hold_start: 0, exp_done: 0, exp_error: 1, exp_words: 0});

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle_after_reset");

    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].len, vecs[k].gap, vecs[k].fixed, vecs[k].hold_start);
      check_output($sformatf("vec%0d", k), vecs[k].exp_done, vecs[k].exp_error, vecs[k].exp_words);
      if (vecs[k].len == 257 && got_addr.size() > 0)
        check("full_depth_last_addr", got_addr[got_addr.size()-1], 32'h0040_0400);
    end

    for (int r = 0; r < 4; r++) begin
      rl = int'($urandom_range(1, 12));
      apply_stimulus(rl, -1, 1'b0, 1'b0);
      check_output($sformatf("rand%0d", r), 1'b1, 1'b0, rl);
    end

    // Reset in the middle of a word must abandon the load without writing
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_load_reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_write_after_reset", 32'(got_addr.size()), 32'd0);
    apply_stimulus(1, 0, 1'b0, 1'b0);
    check_output("restart_after_reset", 1'b1, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
